// File: rtl/io_input_port_if.sv
// Read-side bus between the core's input instruction and the input port buffer.
interface io_input_port_if;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        data_valid;
  logic        stall;
  logic        overrun;

  modport master (output rd_en, input rd_data, data_valid, stall, overrun);
  modport slave  (input rd_en, output rd_data, data_valid, stall, overrun);
endinterface

// File: rtl/io_input_port.sv
// Switch-bank input port: synchronizes switches and a bouncy confirm button,
// debounces the press and presents the captured value as a one-entry handshaked buffer.
module io_input_port #(
  parameter int unsigned DATA_WIDTH      = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  confirm_n,
  io_input_port_if.slave        bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMING  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                  btn_m;
  logic                  btn_s;
  logic [DATA_WIDTH-1:0] sw_m;
  logic [DATA_WIDTH-1:0] sw_s;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  capture;

  logic [DATA_WIDTH-1:0] hold;
  logic                  valid;
  logic                  ovr;
  logic                  read;

  // Two-flop synchronizers; button idles high so it resets released
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_m <= 1'b1;
      btn_s <= 1'b1;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= confirm_n;
      btn_s <= btn_m;
      sw_m  <= in;
      sw_s  <= sw_m;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Debounce: a press needs DEBOUNCE_CYCLES synced lows, re-arming needs as many synced highs
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!btn_s) begin
          state_next = ARMING;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      ARMING: begin
        if (btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      RELEASE: begin
        if (!btn_s) begin
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign read = bus.rd_en & valid;

  // A capture in the same cycle as a read refills the buffer without flagging overrun
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold  <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (capture) begin
        hold <= sw_s;
        if (valid && !read) ovr <= 1'b1;
      end
      valid <= capture | (valid & ~read);
    end
  end

  assign bus.data_valid = valid;
  assign bus.overrun    = ovr;
  assign bus.stall      = bus.rd_en & ~valid;
  assign bus.rd_data    = read ? 32'(hold) : 32'd0;

endmodule
